scan_seq_8ch: RTL and testbench
===============================

# scan_seq_8ch

Channel scan sequencer that drives the 3-bit select of the 8-to-1, 4-bit multiplexer stage and captures that multiplexer's output. It steps round-robin through an enable mask of channels. On each enabled channel it holds the select for a programmable dwell time, then registers the sampled nibble with a one-cycle valid strobe. It is the control stage directly upstream (select) and downstream (data) of the channel multiplexer.

## Interface
Parameters:
- DWELL, 4, cycles the select is held per channel before sampling; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  level; in IDLE with mask != 0, begins scanning
- stop  input  1  level; returns to IDLE at the next edge; wins over start
- mask  input  8  channel enable, bit k = channel k
- d  input  4  multiplexer output for the currently driven select
- s2, s1, s0  output  1 each  select to the multiplexer, {s2,s1,s0} = channel
- q  output  4  last sampled nibble
- ch  output  3  channel that q was sampled from
- valid  output  1  one-cycle pulse, new q/ch
- sweep_done  output  1  one-cycle pulse with the valid of the last channel in a sweep
- busy  output  1  high in SCAN

## Operation
- Reset values: {s2,s1,s0}=000, q=0, ch=0, valid=0, sweep_done=0, busy=0, dwell counter=0, state IDLE.
- FSM states:
  - IDLE: if stop, stay. Else if start and mask != 0, go to SCAN, load select with the lowest set bit of mask, and clear the counter. If start and mask == 0, stay IDLE.
  - SCAN: the counter increments each cycle. On the edge that ends dwell cycle DWELL (counter == DWELL-1):
    - q<=d, ch<=current select, valid<=1.
    - The select advances to the next set mask bit above the current one, wrapping 7->0. Mask is re-read at this edge.
    - If the current channel is the only set bit, the select stays and a new dwell starts.
    - If mask == 0, the select holds and the FSM goes to IDLE after the sample.
  - stop in SCAN: next edge goes to IDLE with no sample and no valid; select, q and ch hold.
- sweep_done asserts with valid when the advance wraps, i.e. the next enabled channel index is <= the current one. This includes the single-channel case.
- Select lines hold their value in IDLE; they change only at channel advance or at a start.
- mask changes mid-dwell do not abort the current dwell.

## Timing
- The select is stable for exactly DWELL cycles per channel. d is sampled in the last of those cycles, leaving DWELL-1 settle cycles.
- valid is high during the first cycle of the next channel's dwell, coincident with updated q and ch.
- Start to first valid: 1 + DWELL cycles. Steady-state sample period: DWELL cycles.
- busy rises on the edge that enters SCAN and falls on the edge that enters IDLE.
- Asynchronous reset mid-scan forces all reset values immediately. No valid is emitted for the interrupted channel.

## Configuration
- SCAN_PEAK_EN defined adds these outputs:
  - peak (4 bits) and peak_ch (3 bits), both reset to 0.
  - Both clear on the edge entering SCAN.
  - On each valid, if the new q > peak (strict comparison), peak<=q and peak_ch<=ch; on ties the earlier channel is retained.
  - Both hold in IDLE.
- SCAN_PEAK_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset/idle: rst_n low mid-scan -> all outputs 0 that same cycle; start with mask=0 -> busy stays 0, no valid.
- Basic scan: DWELL=4, mask=8'b1000_0101, bench mux returns d=k+1 for channel k, start pulsed. Required response:
  - select sequence 0,2,7,0 with 4 cycles each;
  - valid pairs (q,ch) = (1,0),(3,2),(8,7);
  - sweep_done together with (8,7);
  - first valid 5 cycles after start.
- Single channel: mask=8'b0001_0000 -> select constant 100; valid and sweep_done every 4 cycles with q=5.
- Stop priority: start and stop high together in IDLE -> stays IDLE. Stop at dwell cycle 2 -> IDLE next edge, no valid, select held.
- Mask change: clear mask to 0 mid-dwell on channel 2 -> sample (3,2) emitted, then IDLE; set bit 5 during channel 0 dwell -> next select 5.
- SCAN_PEAK_EN: d values 6,9,9,2 on channels 0,1,3,4 -> peak=9, peak_ch=1; restart clears both to 0.

Source files
------------

// File: rtl/scan_seq_8ch.sv
// Round-robin channel scan sequencer for an 8-to-1 nibble multiplexer: drives the select, dwells, samples.
// Optional peak tracker (peak / peak_ch outputs) is built only when SCAN_PEAK_EN is defined.
module scan_seq_8ch #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] mask,
  input  logic [3:0] d,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic [3:0] q,
  output logic [2:0] ch,
  output logic       valid,
  output logic       sweep_done,
  output logic       busy
`ifdef SCAN_PEAK_EN
  ,
  output logic [3:0] peak,
  output logic [2:0] peak_ch
`endif
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [3:0] LAST_CNT = 4'(DWELL - 1);

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Returns {wrap, index} of the next enabled channel above cur; a lone cur bit maps back to itself.
  function automatic logic [3:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] idx;
    logic [2:0] cand;
    logic       found;
    idx   = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = cur + 3'(i);
      if (m[cand] && !found) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return {(idx <= cur), idx};
  endfunction

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] q_q, q_d;
  logic [2:0] ch_q, ch_d;
  logic       valid_q, valid_d;
  logic       sweep_q, sweep_d;
  logic       busy_q, busy_d;
  logic [3:0] adv_s;
`ifdef SCAN_PEAK_EN
  logic [3:0] peak_q, peak_d;
  logic [2:0] peak_ch_q, peak_ch_d;
`endif

  // Next-state, select, sample and pulse logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    ch_d      = ch_q;
    valid_d   = 1'b0;
    sweep_d   = 1'b0;
`ifdef SCAN_PEAK_EN
    peak_d    = peak_q;
    peak_ch_d = peak_ch_q;
`endif
    adv_s     = next_set(mask, sel_q);
    case (state_q)
      IDLE: begin
        if (stop) begin
          cnt_d = 4'd0;
        end else if (start && (mask != 8'd0)) begin
          state_d = SCAN;
          sel_d   = lowest_set(mask);
          cnt_d   = 4'd0;
`ifdef SCAN_PEAK_EN
          peak_d    = 4'd0;
          peak_ch_d = 3'd0;
`endif
        end else begin
          cnt_d = 4'd0;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d   = 4'd0;
          q_d     = d;
          ch_d    = sel_q;
          valid_d = 1'b1;
`ifdef SCAN_PEAK_EN
          if (d > peak_q) begin
            peak_d    = d;
            peak_ch_d = sel_q;
          end else begin
            peak_d    = peak_q;
            peak_ch_d = peak_ch_q;
          end
`endif
          // An empty mask ends the scan after this last sample; the select is left where it was.
          if (mask == 8'd0) begin
            state_d = IDLE;
          end else begin
            sel_d   = adv_s[2:0];
            sweep_d = adv_s[3];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == SCAN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      cnt_q     <= 4'd0;
      q_q       <= 4'd0;
      ch_q      <= 3'd0;
      valid_q   <= 1'b0;
      sweep_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SCAN_PEAK_EN
      peak_q    <= 4'd0;
      peak_ch_q <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      sweep_q   <= sweep_d;
      busy_q    <= busy_d;
`ifdef SCAN_PEAK_EN
      peak_q    <= peak_d;
      peak_ch_q <= peak_ch_d;
`endif
    end
  end

  assign s2         = sel_q[2];
  assign s1         = sel_q[1];
  assign s0         = sel_q[0];
  assign q          = q_q;
  assign ch         = ch_q;
  assign valid      = valid_q;
  assign sweep_done = sweep_q;
  assign busy       = busy_q;
`ifdef SCAN_PEAK_EN
  assign peak       = peak_q;
  assign peak_ch    = peak_ch_q;
`endif

endmodule

// File: tb/tb_scan_seq_8ch.sv
// Directed, table-driven bench for scan_seq_8ch (DWELL=4) with an 8-entry nibble mux model on d.
module tb_scan_seq_8ch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] mask;
  logic [3:0] d;
  logic       s2, s1, s0;
  logic [3:0] q;
  logic [2:0] ch;
  logic       valid;
  logic       sweep_done;
  logic       busy;
`ifdef SCAN_PEAK_EN
  logic [3:0] peak;
  logic [2:0] peak_ch;
`endif

  logic [3:0] dmap [8];
  int n_chk;
  int n_err;

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       valid;
    logic [3:0] q;
    logic [2:0] ch;
    logic       sweep;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  scan_seq_8ch #(.DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mask(mask), .d(d),
    .s2(s2), .s1(s1), .s0(s0), .q(q), .ch(ch), .valid(valid),
    .sweep_done(sweep_done), .busy(busy)
`ifdef SCAN_PEAK_EN
    , .peak(peak), .peak_ch(peak_ch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplexer: channel k returns dmap[k].
  always_comb d = dmap[{s2, s1, s0}];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic st, input logic sp, input logic [7:0] m, input logic [2:0] sel,
                     input logic v, input logic [3:0] qq, input logic [2:0] cc, input logic sw,
                     input logic b);
    vec_t r;
    r.start = st; r.stop = sp; r.mask = m; r.sel = sel; r.valid = v;
    r.q = qq; r.ch = cc; r.sweep = sw; r.busy = b;
    tbl.push_back(r);
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, ".sel"}, {5'd0, s2, s1, s0}, 8'd0);
    chk({tag, ".q"}, {4'd0, q}, 8'd0);
    chk({tag, ".ch"}, {5'd0, ch}, 8'd0);
    chk({tag, ".valid"}, {7'd0, valid}, 8'd0);
    chk({tag, ".sweep"}, {7'd0, sweep_done}, 8'd0);
    chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    int nv;
    n_chk = 0;
    n_err = 0;
    for (int k = 0; k < 8; k++) dmap[k] = 4'(k + 1);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mask = 8'd0;

    // Basic scan over channels 0,2,7 followed by a stop one cycle into the next dwell.
    row(1'b1, 1'b0, 8'h85, 3'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) row(1'b0, 1'b0, 8'h85, 3'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 1'b0, 8'h85, 3'd2, 1'b1, 4'd1, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) row(1'b0, 1'b0, 8'h85, 3'd2, 1'b0, 4'd1, 3'd0, 1'b0, 1'b1);
    row(1'b0, 1'b0, 8'h85, 3'd7, 1'b1, 4'd3, 3'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) row(1'b0, 1'b0, 8'h85, 3'd7, 1'b0, 4'd3, 3'd2, 1'b0, 1'b1);
    row(1'b0, 1'b0, 8'h85, 3'd0, 1'b1, 4'd8, 3'd7, 1'b1, 1'b1);
    row(1'b0, 1'b0, 8'h85, 3'd0, 1'b0, 4'd8, 3'd7, 1'b0, 1'b1);
    row(1'b0, 1'b1, 8'h85, 3'd0, 1'b0, 4'd8, 3'd7, 1'b0, 1'b0);
    // Single enabled channel 4: select constant, valid + sweep_done every 4 cycles.
    row(1'b1, 1'b0, 8'h10, 3'd4, 1'b0, 4'd8, 3'd7, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) row(1'b0, 1'b0, 8'h10, 3'd4, 1'b0, 4'd8, 3'd7, 1'b0, 1'b1);
    row(1'b0, 1'b0, 8'h10, 3'd4, 1'b1, 4'd5, 3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) row(1'b0, 1'b0, 8'h10, 3'd4, 1'b0, 4'd5, 3'd4, 1'b0, 1'b1);
    row(1'b0, 1'b0, 8'h10, 3'd4, 1'b1, 4'd5, 3'd4, 1'b1, 1'b1);
    row(1'b0, 1'b1, 8'h10, 3'd4, 1'b0, 4'd5, 3'd4, 1'b0, 1'b0);

    step();
    step();
    chk_all0("reset");
    rst_n = 1'b1;

    // start with an empty mask stays idle
    start = 1'b1; mask = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mask0.busy[%0d]", i), {7'd0, busy}, 8'd0);
      chk($sformatf("mask0.valid[%0d]", i), {7'd0, valid}, 8'd0);
    end
    // stop wins over start in IDLE
    mask = 8'h01; stop = 1'b1;
    step();
    step();
    chk("startstop.busy", {7'd0, busy}, 8'd0);
    start = 1'b0; stop = 1'b0;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; stop = tbl[i].stop; mask = tbl[i].mask;
      step();
      chk($sformatf("tbl[%0d].sel", i), {5'd0, s2, s1, s0}, {5'd0, tbl[i].sel});
      chk($sformatf("tbl[%0d].valid", i), {7'd0, valid}, {7'd0, tbl[i].valid});
      chk($sformatf("tbl[%0d].q", i), {4'd0, q}, {4'd0, tbl[i].q});
      chk($sformatf("tbl[%0d].ch", i), {5'd0, ch}, {5'd0, tbl[i].ch});
      chk($sformatf("tbl[%0d].sweep", i), {7'd0, sweep_done}, {7'd0, tbl[i].sweep});
      chk($sformatf("tbl[%0d].busy", i), {7'd0, busy}, {7'd0, tbl[i].busy});
    end
    start = 1'b0; stop = 1'b0;

    // Stop during dwell cycle 2: idle next edge, select/q/ch held, no valid afterwards.
    start = 1'b1; mask = 8'h85;
    step();
    start = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop.busy", {7'd0, busy}, 8'd0);
    chk("stop.sel", {5'd0, s2, s1, s0}, 8'd0);
    chk("stop.q", {4'd0, q}, 8'd5);
    chk("stop.ch", {5'd0, ch}, 8'd4);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid) nv++;
    end
    chk("stop.novalid", 8'(nv), 8'd0);

    // Clearing the mask mid-dwell on channel 2 still emits (3,2), then idles.
    start = 1'b1; mask = 8'h85;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("mclr.sel2", {5'd0, s2, s1, s0}, 8'd2);
    step();
    mask = 8'd0;
    repeat (2) step();
    chk("mclr.prevalid", {7'd0, valid}, 8'd0);
    step();
    chk("mclr.valid", {7'd0, valid}, 8'd1);
    chk("mclr.q", {4'd0, q}, 8'd3);
    chk("mclr.ch", {5'd0, ch}, 8'd2);
    chk("mclr.busy", {7'd0, busy}, 8'd0);
    chk("mclr.sel", {5'd0, s2, s1, s0}, 8'd2);
    chk("mclr.sweep", {7'd0, sweep_done}, 8'd0);
    step();
    chk("mclr.pulse", {7'd0, valid}, 8'd0);

    // Setting bit 5 during the channel 0 dwell redirects the next select to 5.
    start = 1'b1; mask = 8'h81;
    step();
    start = 1'b0;
    chk("mset.sel0", {5'd0, s2, s1, s0}, 8'd0);
    step();
    mask = 8'hA1;
    repeat (3) step();
    chk("mset.valid", {7'd0, valid}, 8'd1);
    chk("mset.q", {4'd0, q}, 8'd1);
    chk("mset.sel", {5'd0, s2, s1, s0}, 8'd5);
    repeat (4) step();
    chk("mset.q5", {4'd0, q}, 8'd6);
    chk("mset.ch5", {5'd0, ch}, 8'd5);
    chk("mset.sel7", {5'd0, s2, s1, s0}, 8'd7);
    stop = 1'b1;
    step();
    stop = 1'b0;

`ifdef SCAN_PEAK_EN
    // Peak tracking: 6,9,9,2 on channels 0,1,3,4 keeps the first 9 (channel 1).
    dmap[0] = 4'd6; dmap[1] = 4'd9; dmap[3] = 4'd9; dmap[4] = 4'd2;
    start = 1'b1; mask = 8'h1B;
    step();
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 40 && nv < 4; i++) begin
      step();
      if (valid) nv++;
    end
    chk("peak.nvalid", 8'(nv), 8'd4);
    chk("peak.val", {4'd0, peak}, 8'd9);
    chk("peak.ch", {5'd0, peak_ch}, 8'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("peak.idlehold", {4'd0, peak}, 8'd9);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("peak.clr", {4'd0, peak}, 8'd0);
    chk("peakch.clr", {5'd0, peak_ch}, 8'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int k = 0; k < 8; k++) dmap[k] = 4'(k + 1);
`endif

    // Asynchronous reset mid-scan clears everything before the next edge.
    start = 1'b1; mask = 8'h85;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("prerst.q", {4'd0, q}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all0("asyncrst");
    step();
    chk_all0("rsthold");
    rst_n = 1'b1;
    step();
    chk("postrst.busy", {7'd0, busy}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
